// File: rtl/conv_window_gen.sv
// Sliding F x F window generator: buffers F-1 image rows and emits each fully
// populated window of a raster-order pixel stream through a valid/ready output register.
module conv_window_gen #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned F          = 3,
    parameter int unsigned W          = 8,
    parameter int unsigned H          = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         pixel_in,
    input  logic                          pixel_valid,
    output logic                          pixel_ready,
    output logic [0:F*F*DATA_WIDTH-1]     window,
    output logic                          window_valid,
    input  logic                          window_ready,
    output logic                          window_last,
    output logic                          frame_done
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned RW = (H > 1) ? $clog2(H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
    localparam logic [CW-1:0] COL_MIN = CW'(F - 1);
    localparam logic [RW-1:0] ROW_MIN = RW'(F - 1);

    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    // line_q[i][W-1] holds the pixel accepted (i+1)*W acceptances ago
    logic [DATA_WIDTH-1:0] line_q [F-1][W];
    logic [DATA_WIDTH-1:0] win_q  [F][F];
    logic [DATA_WIDTH-1:0] row_src [F];
    logic [0:F*F*DATA_WIDTH-1] win_next;

    logic accept;
    logic at_col_end;
    logic at_frame_end;
    logic emit;

    assign pixel_ready  = !window_valid || window_ready;
    assign accept       = pixel_valid && pixel_ready;
    assign at_col_end   = (col_q == COL_MAX);
    assign at_frame_end = at_col_end && (row_q == ROW_MAX);
    assign emit         = accept && (row_q >= ROW_MIN) && (col_q >= COL_MIN);

    // Column entering each window row on this acceptance; row F-1 is the live pixel.
    always_comb begin
        row_src[F-1] = pixel_in;
        for (int r = 0; r < F - 1; r++) begin
            row_src[r] = line_q[F-2-r][W-1];
        end
    end

    // Window contents as they will look once the current pixel is shifted in.
    always_comb begin
        win_next = '0;
        for (int r = 0; r < F; r++) begin
            for (int c = 0; c < F - 1; c++) begin
                win_next[(r*F+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c+1];
            end
            win_next[(r*F+F-1)*DATA_WIDTH +: DATA_WIDTH] = row_src[r];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line_q[0][0] <= pixel_in;
            for (int i = 1; i < F - 1; i++) begin
                line_q[i][0] <= line_q[i-1][W-1];
            end
            for (int i = 0; i < F - 1; i++) begin
                for (int j = 1; j < W; j++) begin
                    line_q[i][j] <= line_q[i][j-1];
                end
            end
            for (int r = 0; r < F; r++) begin
                for (int c = 0; c < F - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][F-1] <= row_src[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            window       <= '0;
            window_valid <= 1'b0;
            window_last  <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= accept && at_frame_end;
            if (accept) begin
                if (at_col_end) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            if (emit) begin
                window       <= win_next;
                window_valid <= 1'b1;
                window_last  <= at_frame_end;
            end else if (window_ready) begin
                window_valid <= 1'b0;
                window_last  <= 1'b0;
            end
        end
    end

endmodule
